// File: rtl/pp_pkg.sv
// Shared widths, width-derivation functions and lane decode record
// for the partial-product array pipeline.
package pp_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_IMG_EXP_W  = 5;
    localparam int DEF_IMG_MANT_W = 2;
    localparam int DEF_WGT_EXP_W  = 3;

    // image word: {sign, exp, mant}
    function automatic int pp_iw(input int exp_w, input int mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    // weight word: {sign, exp}
    function automatic int pp_ww(input int wexp_w);
        return 1 + wexp_w;
    endfunction

    // denormalised partial product: {sign, 1, mant}
    function automatic int pp_pw(input int mant_w);
        return mant_w + 2;
    endfunction

    // exponent sum; one carry bit covers img_exp + wgt_exp
    function automatic int pp_xw(input int exp_w);
        return exp_w + 1;
    endfunction

    localparam int IW = pp_iw(DEF_IMG_EXP_W, DEF_IMG_MANT_W);
    localparam int WW = pp_ww(DEF_WGT_EXP_W);
    localparam int PW = pp_pw(DEF_IMG_MANT_W);
    localparam int XW = pp_xw(DEF_IMG_EXP_W);

    // one decoded lane at the default geometry
    typedef struct packed {
        logic                      sign;
        logic [XW-1:0]             exp;
        logic [DEF_IMG_MANT_W-1:0] mant;
        logic                      zero;
    } lane_dec_t;

endpackage

// File: rtl/pp_lane.sv
// Per-lane decode: zero detect, product sign and exponent sum.
// Ports: image {sign,exp,mant}, weight {sign,exp} in; sign, zero, exp, mant out.
module pp_lane
    import pp_pkg::*;
#(
    parameter int IMG_EXP_W  = DEF_IMG_EXP_W,
    parameter int IMG_MANT_W = DEF_IMG_MANT_W,
    parameter int WGT_EXP_W  = DEF_WGT_EXP_W,
    localparam int LIW = pp_iw(IMG_EXP_W, IMG_MANT_W),
    localparam int LWW = pp_ww(WGT_EXP_W),
    localparam int LXW = pp_xw(IMG_EXP_W)
) (
    input  logic [LIW-1:0]        image,
    input  logic [LWW-1:0]        weight,
    output logic                  sign,
    output logic                  zero,
    output logic [LXW-1:0]        exp,
    output logic [IMG_MANT_W-1:0] mant
);

    logic                  img_sign;
    logic [IMG_EXP_W-1:0]  img_exp;
    logic [IMG_MANT_W-1:0] img_mant;
    logic                  wgt_sign;
    logic [WGT_EXP_W-1:0]  wgt_exp;

    assign img_sign = image[LIW-1];
    assign img_exp  = image[IMG_MANT_W +: IMG_EXP_W];
    assign img_mant = image[IMG_MANT_W-1:0];
    assign wgt_sign = weight[LWW-1];
    assign wgt_exp  = weight[WGT_EXP_W-1:0];

    // A zero lane reports all-zero fields, so a signed zero
    // image never leaks its sign into the product.
    always_comb begin
        zero = ((img_exp == '0) && (img_mant == '0)) || (&wgt_exp);
        sign = 1'b0;
        exp  = '0;
        mant = '0;
        if (!zero) begin
            sign = img_sign ^ wgt_sign;
            exp  = {1'b0, img_exp}
                 + {{(LXW-WGT_EXP_W){1'b0}}, wgt_exp};
            mant = img_mant;
        end
    end

endmodule

// File: rtl/pp_array_pipe.sv
// Two-stage partial-product array with valid/ready flow control and held weights.
// Ports: clk, rst, in_valid/in_ready, image, weight, wgt_load, wgt_sel,
//   out_valid/out_ready, denorm_pp, exp, zero_mask, max_exp.
// Optional PP_ARRAY_STATS_EN adds saturating beat_cnt and zero_cnt outputs.
// WGT_EXP_W must not exceed IMG_EXP_W.
module pp_array_pipe
    import pp_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int IMG_EXP_W  = DEF_IMG_EXP_W,
    parameter int IMG_MANT_W = DEF_IMG_MANT_W,
    parameter int WGT_EXP_W  = DEF_WGT_EXP_W,
    localparam int AIW = pp_iw(IMG_EXP_W, IMG_MANT_W),
    localparam int AWW = pp_ww(WGT_EXP_W),
    localparam int APW = pp_pw(IMG_MANT_W),
    localparam int AXW = pp_xw(IMG_EXP_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*AIW-1:0] image,
    input  logic [LANES*AWW-1:0] weight,
    input  logic                 wgt_load,
    input  logic                 wgt_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*APW-1:0] denorm_pp,
    output logic [LANES*AXW-1:0] exp,
    output logic [LANES-1:0]     zero_mask,
    output logic [AXW-1:0]       max_exp
`ifdef PP_ARRAY_STATS_EN
    ,
    output logic [31:0]          beat_cnt,
    output logic [31:0]          zero_cnt
`endif
);

    localparam logic [AWW-1:0] WGT_ZERO = {1'b0, {WGT_EXP_W{1'b1}}};

    // handshake
    logic s2_ld;
    logic s1_adv;
    logic accept;
    logic in_ready_c;

    // weight selection
    logic [LANES*AWW-1:0] held_q, held_d;
    logic [LANES*AWW-1:0] wgt_use;

    // lane decode outputs
    logic [LANES-1:0]                 lane_sign;
    logic [LANES-1:0]                 lane_zero;
    logic [LANES-1:0][AXW-1:0]        lane_exp;
    logic [LANES-1:0][IMG_MANT_W-1:0] lane_mant;

    // stage 1
    logic                             s1_valid_q, s1_valid_d;
    logic [LANES-1:0]                 s1_sign_q, s1_sign_d;
    logic [LANES-1:0]                 s1_zero_q, s1_zero_d;
    logic [LANES-1:0][AXW-1:0]        s1_exp_q, s1_exp_d;
    logic [LANES-1:0][IMG_MANT_W-1:0] s1_mant_q, s1_mant_d;

    // stage 2 (output registers)
    logic                 out_valid_q, out_valid_d;
    logic [LANES*APW-1:0] denorm_pp_q, denorm_pp_d;
    logic [LANES*AXW-1:0] exp_q, exp_d;
    logic [LANES-1:0]     zero_mask_q, zero_mask_d;
    logic [AXW-1:0]       max_exp_q, max_exp_d;

    // stage-2 values formed from stage 1
    logic [LANES*APW-1:0] s2_pp;
    logic [LANES*AXW-1:0] s2_exp;
    logic [LANES-1:0]     s2_zm;
    logic [AXW-1:0]       s2_max;

    // A load on the same beat wins, so that beat sees the new weights.
    assign wgt_use = (wgt_sel && !wgt_load) ? held_q : weight;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pp_lane #(
            .IMG_EXP_W  (IMG_EXP_W),
            .IMG_MANT_W (IMG_MANT_W),
            .WGT_EXP_W  (WGT_EXP_W)
        ) u_lane (
            .image  (image[g*AIW +: AIW]),
            .weight (wgt_use[g*AWW +: AWW]),
            .sign   (lane_sign[g]),
            .zero   (lane_zero[g]),
            .exp    (lane_exp[g]),
            .mant   (lane_mant[g])
        );
    end

    always_comb begin
        // in_ready depends only on state and out_ready
        s2_ld      = !out_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_ld;
        in_ready_c = !s1_valid_q || s1_adv;
        accept     = in_valid && in_ready_c;

        held_d = held_q;
        if (accept && wgt_load) begin
            held_d = weight;
        end

        s1_valid_d = in_ready_c ? in_valid : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        if (accept) begin
            s1_sign_d = lane_sign;
            s1_zero_d = lane_zero;
            s1_exp_d  = lane_exp;
            s1_mant_d = lane_mant;
        end

        s2_pp  = '0;
        s2_exp = '0;
        s2_zm  = '0;
        s2_max = '0;
        for (int i = 0; i < LANES; i++) begin
            s2_zm[i] = s1_zero_q[i];
            if (!s1_zero_q[i]) begin
                s2_pp[i*APW +: APW] = {s1_sign_q[i], 1'b1, s1_mant_q[i]};
                s2_exp[i*AXW +: AXW] = s1_exp_q[i];
                if (s1_exp_q[i] > s2_max) begin
                    s2_max = s1_exp_q[i];
                end
            end
        end

        out_valid_d = s2_ld ? s1_valid_q : out_valid_q;
        denorm_pp_d = s1_adv ? s2_pp : denorm_pp_q;
        exp_d       = s1_adv ? s2_exp : exp_q;
        zero_mask_d = s1_adv ? s2_zm : zero_mask_q;
        max_exp_d   = s1_adv ? s2_max : max_exp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q      <= {LANES{WGT_ZERO}};
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= '0;
            s1_zero_q   <= '0;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            out_valid_q <= 1'b0;
            denorm_pp_q <= '0;
            exp_q       <= '0;
            zero_mask_q <= '0;
            max_exp_q   <= '0;
        end else begin
            held_q      <= held_d;
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_q   <= s1_mant_d;
            out_valid_q <= out_valid_d;
            denorm_pp_q <= denorm_pp_d;
            exp_q       <= exp_d;
            zero_mask_q <= zero_mask_d;
            max_exp_q   <= max_exp_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign denorm_pp = denorm_pp_q;
    assign exp       = exp_q;
    assign zero_mask = zero_mask_q;
    assign max_exp   = max_exp_q;

`ifdef PP_ARRAY_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] zero_cnt_q, zero_cnt_d;
    logic [31:0] zero_pop;
    logic [32:0] zero_sum;

    always_comb begin
        zero_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            zero_pop = zero_pop + 32'(zero_mask_q[i]);
        end
        zero_sum   = {1'b0, zero_cnt_q} + {1'b0, zero_pop};
        beat_cnt_d = beat_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (out_valid_q && out_ready) begin
            if (beat_cnt_q != 32'hFFFF_FFFF) begin
                beat_cnt_d = beat_cnt_q + 32'd1;
            end
            // carry out of the 33-bit sum means saturation
            zero_cnt_d = zero_sum[32] ? 32'hFFFF_FFFF : zero_sum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            zero_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_pp_array_pipe.sv
// Scoreboard bench for pp_array_pipe at default parameters.
// Expected beats are queued at acceptance and compared at output.
module tb_pp_array_pipe;

    localparam int LANES = 4;

    typedef struct packed {
        logic [15:0] pp;
        logic [23:0] ex;
        logic [3:0]  zm;
        logic [5:0]  mx;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] image = '0;
    logic [15:0] weight = '0;
    logic        wgt_load = 1'b0;
    logic        wgt_sel = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] denorm_pp;
    logic [23:0] exp_o;
    logic [3:0]  zero_mask;
    logic [5:0]  max_exp;
`ifdef PP_ARRAY_STATS_EN
    logic [31:0] beat_cnt;
    logic [31:0] zero_cnt;
    logic [31:0] m_beats = '0;
    logic [31:0] m_zeros = '0;
`endif

    res_t        sbq[$];
    logic [15:0] m_held = 16'h7777;
    logic        hold_pend = 1'b0;
    res_t        hold_val;
    int          n_chk = 0;
    int          n_pass = 0;
    int          rdy_mode = 0;

    always #5 clk = ~clk;

    pp_array_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .image     (image),
        .weight    (weight),
        .wgt_load  (wgt_load),
        .wgt_sel   (wgt_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .denorm_pp (denorm_pp),
        .exp       (exp_o),
        .zero_mask (zero_mask),
        .max_exp   (max_exp)
`ifdef PP_ARRAY_STATS_EN
        ,
        .beat_cnt  (beat_cnt),
        .zero_cnt  (zero_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic res_t model(input logic [31:0] img,
                                   input logic [15:0] w);
        res_t       r;
        logic [7:0] li;
        logic [3:0] lw;
        logic [5:0] x;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            li = img[i*8 +: 8];
            lw = w[i*4 +: 4];
            if ((li[6:0] == 7'd0) || (lw[2:0] == 3'b111)) begin
                r.zm[i] = 1'b1;
            end else begin
                r.pp[i*4 +: 4] = {li[7] ^ lw[3], 1'b1, li[1:0]};
                x = {1'b0, li[6:2]} + {3'b000, lw[2:0]};
                r.ex[i*6 +: 6] = x;
                if (x > r.mx) r.mx = x;
            end
        end
        return r;
    endfunction

    // out_ready pattern: 0 always, 1 toggle, 2 random, 3 stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // monitor: model acceptance, score outputs, check stall stability
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        logic [15:0] sel;
        cur = {denorm_pp, exp_o, zero_mask, max_exp};
        if (rst) begin
            sbq.delete();
            m_held    = 16'h7777;
            hold_pend = 1'b0;
`ifdef PP_ARRAY_STATS_EN
            m_beats = '0;
            m_zeros = '0;
`endif
        end else begin
`ifdef PP_ARRAY_STATS_EN
            chk("beat_cnt", 64'(beat_cnt), 64'(m_beats));
            chk("zero_cnt", 64'(zero_cnt), 64'(m_zeros));
`endif
            if (hold_pend) begin
                chk("hold", {out_valid, cur}, {1'b1, hold_val});
            end
            if (in_valid && in_ready) begin
                sel = (wgt_sel && !wgt_load) ? m_held : weight;
                sbq.push_back(model(image, sel));
                if (wgt_load) m_held = weight;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("pp", 64'(denorm_pp), 64'(e.pp));
                    chk("exp", 64'(exp_o), 64'(e.ex));
                    chk("zmask", 64'(zero_mask), 64'(e.zm));
                    chk("max", 64'(max_exp), 64'(e.mx));
                end
`ifdef PP_ARRAY_STATS_EN
                m_beats = m_beats + 32'd1;
                m_zeros = m_zeros + 32'($countones(zero_mask));
`endif
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = cur;
        end
    end

    task automatic send(input logic [31:0] img, input logic [15:0] w,
                        input logic ld, input logic sel);
        int n;
        n = 0;
        in_valid = 1'b1;
        image    = img;
        weight   = w;
        wgt_load = ld;
        wgt_sel  = sel;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wgt_load = 1'b0;
        wgt_sel  = 1'b0;
    endtask

    initial begin
        int n;
        #1_000_000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        int n;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data", {denorm_pp, exp_o, zero_mask, max_exp}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // single beat, exact latency and fixed values
        send(32'h0000_000E, 16'h777A, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_s2", 64'(out_valid), 64'd1);
        chk("l0_pp", 64'(denorm_pp[3:0]), 64'hE);
        chk("l0_exp", 64'(exp_o[5:0]), 64'd5);
        chk("l0_zm", 64'(zero_mask), 64'hE);
        chk("l0_max", 64'(max_exp), 64'd5);

        // negative zero and zero weight lanes excluded from max
        send({8'h09, 8'h7F, 8'h80, 8'h11}, {4'h1, 4'h7, 4'h1, 4'h1},
             1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("nz_valid", 64'(out_valid), 64'd1);
        chk("nz_zm", 64'(zero_mask), 64'h6);
        chk("nz_pp", 64'(denorm_pp[11:4]), 64'd0);
        chk("nz_exp", 64'(exp_o[17:6]), 64'd0);
        chk("nz_max", 64'(max_exp), 64'd5);

        // ten back-to-back beats under toggling backpressure
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send($urandom, 16'($urandom), 1'b0, 1'b0);
        end
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;

        // held weights, then bus weight zero with sel = 1
        send(32'h4B2D_6F13, 16'h1A3C, 1'b1, 1'b0);
        send(32'h2145_8C7E, 16'h0000, 1'b0, 1'b1);
        send(32'h8000_0080, 16'h0000, 1'b0, 1'b1);
        send(32'h5566_7788, 16'h0000, 1'b0, 1'b1);
        // load and use on the same beat
        send(32'h3344_5566, 16'h2B41, 1'b1, 1'b1);
        send(32'h6677_8899, 16'h0000, 1'b0, 1'b1);

        // random traffic and backpressure
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send($urandom, 16'($urandom),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;

        // reset with two beats in flight
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        send(32'h1234_5678, 16'h1234, 1'b0, 1'b0);
        send(32'h2345_6789, 16'h2345, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_data", {denorm_pp, exp_o, zero_mask, max_exp}, 64'd0);
`ifdef PP_ARRAY_STATS_EN
        chk("rst2_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2_empty", 64'(out_valid), 64'd0);
        // held weights were cleared to zero weight
        send(32'h1234_5678, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_zm", 64'(zero_mask), 64'hF);
        send(32'h0C0C_0C0C, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_max", 64'(max_exp), 64'd4);

        // drain
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pp_array_pipe.md
PP_ARRAY_PIPE -- requirements
Module: pp_array_pipe

Interface
REQ-001 Parameter LANES, default 4: number of independent partial-product lanes.
REQ-002 Parameter IMG_EXP_W, default 5: image exponent bits. Parameter IMG_MANT_W, default 2: image mantissa bits. Parameter WGT_EXP_W, default 3: weight exponent bits, legal only when WGT_EXP_W <= IMG_EXP_W.
REQ-003 Port widths derive from the parameters: IW = 1+IMG_EXP_W+IMG_MANT_W, WW = 1+WGT_EXP_W, PW = IMG_MANT_W+2, XW = IMG_EXP_W+1.
REQ-004 Ports (name, direction, width, meaning), in this order:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: input beat accepted when in_valid && in_ready.
- image, in, LANES*IW: lane i at [i*IW +: IW]; fields {sign, exp, mant}.
- weight, in, LANES*WW: fields {sign, exp}; exp all-ones encodes zero weight.
- wgt_load, in, 1: on an accepted beat, latch the weight bus into the held-weight register.
- wgt_sel, in, 1: 0 = use the weight bus; 1 = use the held weights.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts.
- denorm_pp, out, LANES*PW: per lane {sign, 1, mant}.
- exp, out, LANES*XW: per-lane exponent sum.
- zero_mask, out, LANES: bit i set when lane i is zero.
- max_exp, out, XW: maximum exp over the non-zero lanes.

Function
REQ-005 A lane SHALL be zero when its image exp and mant are both all-zero, or when its selected weight exp is all-ones.
REQ-006 A non-zero lane SHALL output denorm_pp = {img_sign XOR wgt_sign, 1'b1, img_mant} and exp = img_exp + zero-extended wgt_exp, computed in XW bits with no overflow possible.
REQ-007 A zero lane SHALL output denorm_pp = 0, exp = 0 and zero_mask bit = 1.
REQ-008 max_exp SHALL be the unsigned maximum of exp over the non-zero lanes, and 0 when all lanes are zero.
REQ-009 The block SHALL be a 2-stage pipeline.
- Stage 1 registers: decoded fields, zero flags, XOR sign.
- Stage 2 registers: the output fields, including max_exp.
- Latency is 2 cycles from acceptance to out_valid when out_ready = 1.
REQ-010 Throughput SHALL be one beat per cycle. A stage loads when it is empty or its contents are advancing. in_ready = !s1_valid || s1_advances, with no combinational path from in_valid to in_ready.
REQ-011 While out_valid && !out_ready, all outputs SHALL hold stable. No beat is dropped or duplicated, and backpressure fills both stages before in_ready drops.
REQ-012 With wgt_sel = 1 and wgt_load = 1 on the same accepted beat, that beat SHALL use the newly loaded weight bus. The held register updates only on accepted beats.
REQ-013 A beat with the image sign set and a zero magnitude SHALL still be treated as zero, and its pp sign SHALL be 0.

Reset
REQ-014 While rst = 1, and immediately on assertion, the block SHALL clear:
- s1_valid, out_valid: 0
- all data outputs: 0
- held weights: all lanes exp all-ones (zero)
- in_ready: 1
REQ-015 Reset mid-transfer SHALL discard in-flight beats. The first accepted beat after rst deasserts appears 2 cycles later.

Configuration
REQ-016 With macro PP_ARRAY_STATS_EN defined, the block SHALL add two outputs, each reset to 0:
- beat_cnt[31:0]: counts beats accepted at the output.
- zero_cnt[31:0]: adds the popcount of zero_mask per output beat.
- Both counters saturate at 32'hFFFFFFFF.
REQ-017 Without PP_ARRAY_STATS_EN, those ports and their counters SHALL be absent.

Structure
REQ-018 A shared package pp_pkg SHALL hold:
- the field-width localparams and their derivation functions (IW, WW, PW, XW);
- the lane decode struct typedef {sign, exp, mant, zero}.
REQ-019 One sub-module, pp_lane, SHALL implement the per-lane combinational decode, zero detect, sign and exp add. It SHALL be instantiated LANES times. Pipeline and handshake logic stay in pp_array_pipe.

Verification
REQ-020 Lane 0 image 8'b0_00011_10, weight 4'b1_010, out_ready = 1 -> two cycles later denorm_pp lane 0 = 4'b1110, exp = 6'd5, zero_mask[0] = 0.
REQ-021 Lane 1 image 8'h80 (negative zero) and lane 2 weight 4'b0_111 -> lanes 1 and 2 have pp = 0, exp = 0, zero_mask = 4'b0110; max_exp excludes them.
REQ-022 Ten back-to-back beats with out_ready toggling 1,0,1,0… -> all ten beats emerge in order, outputs stable during stalls, no loss.
REQ-023 Accept a beat with wgt_load = 1, then three beats with wgt_sel = 1 and the weight bus = 0 -> results use the loaded weights; all-zero image lanes give max_exp = 0.
REQ-024 Assert rst with two beats in flight -> out_valid = 0 immediately, the in-flight beats are discarded, in_ready = 1; with PP_ARRAY_STATS_EN defined, beat_cnt = 0.
